// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Iterative shift-add WIDTH x WIDTH multiplier (signed/unsigned),
//            start/busy/done handshake, registered 2*WIDTH result (HI:LO).
//            Optional macro MULT_EARLY_EXIT_EN ends CALC once the remaining
//            multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam logic [1:0]       c_idle = 2'd0;
  localparam logic [1:0]       c_calc = 2'd1;
  localparam logic [1:0]       c_fix  = 2'd2;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mq_q,      mq_d;
  logic               neg_q,     neg_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] dataout_q, dataout_d;
  logic               done_q,    done_d;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_calc_done;
  logic [1:0]         w_idle_next;

  // |-2^(W-1)| = 2^(W-1) still fits when the magnitude is read as unsigned
  assign w_mag_a = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign w_mag_b = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;

`ifdef MULT_EARLY_EXIT_EN
  assign w_calc_done = (cnt_q == c_last) || (mq_q[WIDTH-1:1] == '0);
  assign w_idle_next = (w_mag_b == '0) ? c_fix : c_calc;
`else
  assign w_calc_done = (cnt_q == c_last);
  assign w_idle_next = c_calc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= c_idle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mq_q      <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      dataout_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (start) state_d = w_idle_next;
      c_calc:  if (w_calc_done) state_d = c_fix;
      c_fix:   state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    dataout_d = dataout_q;
    done_d    = 1'b0;
    case (state_q)
      c_idle: begin
        if (start) begin
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, w_mag_a};
          mq_d    = w_mag_b;
          neg_d   = is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          cnt_d   = '0;
        end
      end
      c_calc: begin
        if (mq_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
        mq_d    = {1'b0, mq_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
      end
      c_fix: begin
        dataout_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy    = (state_q != c_idle);
    done    = done_q;
    dataOut = dataout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Self-checking bench for seq_multiplier (WIDTH=32): vector table,
//            back-to-back start, reset abort and reset/start collision.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   dataA;
  logic [W-1:0]   dataB;
  logic           busy;
  logic           done;
  logic [2*W-1:0] dataOut;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .done      (done),
    .dataOut   (dataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic s, input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic [W-1:0] m;
    int k;
    m = (s && b[W-1]) ? -b : b;
    k = 0;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    return k + 1;
`else
    return W + 1;
`endif
  endfunction

  // Issues one start pulse and measures latency and busy cycles up to done.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] res, output int lat, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; is_signed = s; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0; is_signed = ~s; dataA = $urandom; dataB = $urandom;
    lat = -1; busy_cyc = 0; res = '0;
    for (int i = 1; i <= 80; i++) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        res = dataOut;
        break;
      end
    end
  endtask

  vec_t           vecs[13];
  logic [2*W-1:0] res;
  logic [2*W-1:0] last_out;
  logic [2*W-1:0] exp_p;
  int             lat, bcyc, el, dones, next_acc, done_at;
  logic [W-1:0]   cur_a;

  initial begin
    vecs[0]  = '{1'b0, 32'd7,          32'd6,          64'd42};
    vecs[1]  = '{1'b1, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2]  = '{1'b0, 32'hFFFF_FFFD,  32'd5,          64'h0000_0004_FFFF_FFF1};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[5]  = '{1'b1, 32'd0,          32'h8000_0000,  64'd0};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFA,  64'hFFFF_FFFF_FFFF_FFD6};
    vecs[9]  = '{1'b1, 32'h1234_5678,  32'd2,          64'h0000_0000_2468_ACF0};
    vecs[10] = '{1'b0, 32'd9,          32'd1,          64'd9};
    vecs[11] = '{1'b0, 32'd9,          32'd0,          64'd0};
    vecs[12] = '{1'b0, 32'd3,          32'h8000_0000,  64'h0000_0001_8000_0000};

    // Reset asserted together with start: reset must win.
    reset = 1'b1; start = 1'b1; is_signed = 1'b0; dataA = 32'd7; dataB = 32'd6;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dataOut", dataOut, 64'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    for (int v = 0; v < 13; v++) begin
      run_op(vecs[v].s, vecs[v].a, vecs[v].b, res, lat, bcyc);
      el = exp_lat(vecs[v].s, vecs[v].b);
      chk($sformatf("product[%0d]", v), res, vecs[v].p);
      chk($sformatf("latency[%0d]", v), 64'(lat), 64'(el));
      chk($sformatf("busy_cycles[%0d]", v), 64'(bcyc), 64'(el));
      chk($sformatf("busy_after_done[%0d]", v), {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("done_pulse_width[%0d]", v), {63'd0, done}, 64'd0);
      chk($sformatf("hold[%0d]", v), dataOut, vecs[v].p);
    end

    // start held high with operands changing every cycle; multiplier bit 31 set
    // keeps the latency at W+1 in every build.
    last_out = dataOut;
    next_acc = 0; done_at = -1; dones = 0; exp_p = '0;
    for (int c = 0; c < 3 * (W + 2); c++) begin
      @(negedge clk);
      cur_a = 32'd100 + 32'(c);
      start = 1'b1; is_signed = 1'b0; dataA = cur_a; dataB = 32'h8000_0003;
      @(posedge clk);
      if (c == next_acc) begin
        exp_p    = {32'd0, cur_a} * 64'h0000_0000_8000_0003;
        done_at  = c + W + 1;
        next_acc = c + W + 2;
      end
      #1;
      if (c == done_at) begin
        dones++;
        chk($sformatf("stream_done@%0d", c), {63'd0, done}, 64'd1);
        chk($sformatf("stream_product@%0d", c), dataOut, exp_p);
        last_out = exp_p;
      end else begin
        if (done || dataOut !== last_out)
          chk($sformatf("stream_quiet@%0d", c), {done, dataOut}, {1'b0, last_out});
      end
    end
    checks++;
    @(negedge clk);
    start = 1'b0;
    chk("stream_count", 64'(dones), 64'd3);
    repeat (W + 3) @(posedge clk);

    // Reset 10 cycles into an operation aborts it without a done pulse.
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dataA = 32'd5; dataB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_dataOut", dataOut, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run_op(1'b0, 32'd11, 32'd13, res, lat, bcyc);
    chk("after_abort_product", res, 64'd143);
    chk("after_abort_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd13)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
